// File: rtl/ro_stream_fifo.sv
// ro_stream_fifo
//   Watches the Ro output register of the fibonacci datapath. Each new value
//   is queued in a small FIFO, and a slower consumer drains the FIFO through
//   a valid/ready handshake.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset, overrides every other input
//   Ro_in      Ro value from the datapath (bits wide)
//   en         capture enable; when 0, Ro_in is ignored
//   out_data   head-of-FIFO value (show-ahead), 0 when empty
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts out_data this cycle
//   count      entries currently held
//   full       count == DEPTH
//   overflow   sticky: a detected value was dropped because the FIFO was full
module ro_stream_fifo #(
  parameter int unsigned bits  = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [bits-1:0]            Ro_in,
  input  logic                       en,
  output logic [bits-1:0]            out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [bits-1:0] mem_q [DEPTH];

  logic [bits-1:0] last_ro_q, last_ro_d;
  logic            first_q,   first_d;
  logic [PW-1:0]   wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0]   count_q,   count_d;
  logic            ovf_q,     ovf_d;

  logic push_req;
  logic push;
  logic pop;
  logic full_w;
  logic valid_w;

  assign full_w  = (count_q == CW'(DEPTH));
  assign valid_w = (count_q != '0);

  // Change detector, handshake and acceptance decisions.
  always_comb begin
    push_req = en && (first_q || (Ro_in != last_ro_q));
    pop      = valid_w && out_ready;
    // A push into a full FIFO still fits when the head leaves this cycle.
    push     = push_req && (!full_w || pop);
  end

  always_comb begin
    last_ro_d = last_ro_q;
    first_d   = first_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    // The sample is consumed whether or not the push is accepted, so a
    // dropped value is never retried.
    if (en) begin
      last_ro_d = Ro_in;
      first_d   = 1'b0;
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ro_q <= '0;
      first_q   <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      last_ro_q <= last_ro_d;
      first_q   <= first_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: stale entries are never visible because
  // out_data is masked while count is zero.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= Ro_in;
  end

  always_comb begin
    out_data  = valid_w ? mem_q[rd_ptr_q] : '0;
    out_valid = valid_w;
    count     = count_q;
    full      = full_w;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_ro_stream_fifo.sv
module tb_ro_stream_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] Ro_in;
  logic       en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] count;
  logic       full;
  logic       overflow;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  ro_stream_fifo #(.bits(8), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .Ro_in     (Ro_in),
    .en        (en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake that will complete at the next rising edge
  // must present the oldest expected value.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic       have;
      logic [7:0] e;
      have = (exp_q.size() != 0);
      e    = have ? exp_q.pop_front() : 8'hxx;
      n_assert++;
      assert (have && out_data === e) else begin
        n_fail++;
        $error("FAIL stream: observed %0h expected %0h (queue had entry %0d)", out_data, e, have);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; Ro_in = 8'd0;
    tick(2);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Constant Ro collapses to a single entry.
    en = 1'b1; Ro_in = 8'd0;
    exp_q.push_back(8'd0);
    tick(10);
    chk("hold_count", count, 1);
    chk("hold_data", out_data, 0);
    chk("hold_valid", out_valid, 1);
    chk("hold_ovf", overflow, 0);
    out_ready = 1'b1;
    tick(1);
    chk("hold_drained", count, 0);

    // Fibonacci stream with a fast consumer.
    out_ready = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0; out_ready = 1'b1;
    begin
      logic [7:0] seq [8] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
      foreach (seq[k]) if (k == 0 || seq[k] != seq[k-1]) exp_q.push_back(seq[k]);
      for (int v = 0; v < 8; v++) begin
        Ro_in = seq[v];
        for (int r = 0; r < 3; r++) begin
          tick(1);
          chk("fib_count_le1", 32'(count <= 4'd1), 1);
        end
      end
    end
    tick(2);
    chk("fib_empty", count, 0);
    chk("fib_queue_done", exp_q.size(), 0);
    chk("fib_ovf", overflow, 0);

    // Fill to full, overflow on the ninth, then drain in order.
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      Ro_in = 8'(i);
      if (i <= 8) exp_q.push_back(8'(i));
      tick(1);
      if (i == 8) begin
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        chk("fill_ovf0", overflow, 0);
      end
    end
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    out_ready = 1'b1;
    tick(8);
    chk("drain_count", count, 0);
    tick(2);
    chk("drain_valid", out_valid, 0);
    chk("drain_queue_done", exp_q.size(), 0);
    chk("ovf_sticky", overflow, 1);

    // Push while full with a simultaneous pop.
    out_ready = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_ovf", overflow, 0);
    for (int i = 21; i <= 28; i++) begin
      Ro_in = 8'(i);
      exp_q.push_back(8'(i));
      tick(1);
    end
    chk("pp_full_before", full, 1);
    Ro_in = 8'd29; out_ready = 1'b1;
    exp_q.push_back(8'd29);
    tick(1);
    chk("pp_count", count, 8);
    chk("pp_ovf", overflow, 0);
    chk("pp_full", full, 1);
    tick(8);
    chk("pp_drained", count, 0);
    chk("pp_queue_done", exp_q.size(), 0);

    // Enable gating.
    out_ready = 1'b0; en = 1'b1; Ro_in = 8'd5;
    exp_q.push_back(8'd5);
    tick(1);
    chk("en_first", count, 1);
    en = 1'b0; Ro_in = 8'd6;
    tick(1);
    Ro_in = 8'd7;
    tick(1);
    chk("en_off_nopush", count, 1);
    en = 1'b1;
    exp_q.push_back(8'd7);
    tick(1);
    chk("en_reenable", count, 2);
    tick(3);
    chk("en_hold", count, 2);
    out_ready = 1'b1;
    tick(2);
    chk("en_drained", count, 0);

    // Reset mid-stream; first sample afterwards always pushes.
    out_ready = 1'b0;
    for (int i = 41; i <= 45; i++) begin
      Ro_in = 8'(i);
      tick(1);
    end
    chk("mid_count5", count, 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_data", out_data, 0);
    exp_q.push_back(8'd45);
    tick(1);
    chk("post_rst_push", count, 1);
    chk("post_rst_data", out_data, 45);
    out_ready = 1'b1;
    tick(2);
    chk("final_count", count, 0);
    chk("final_queue_done", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
